// File: rtl/seq_alu_calc.sv
// Sequential calculator: button-loaded operands, single-cycle add/sub,
// shift-add multiply and restoring divide/modulo over WIDTH iterations.
module seq_alu_calc #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  input  logic                 btnLoadA,
  input  logic                 btnLoadB,
  input  logic                 btnExec,
  input  logic [2:0]           op,
  output logic [2*WIDTH-1:0]   led_out,
  output logic                 flag_out,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic                 loadAPrev_q, loadBPrev_q, execPrev_q;
  logic [WIDTH-1:0]     regA_q, regA_d, regB_q, regB_d;
  logic [WIDTH-1:0]     aW_q, aW_d, bW_q, bW_d;
  logic [2:0]           opW_q, opW_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   led_q, led_d;
  logic                 flag_q, flag_d;
  logic                 done_q, done_d;

  logic                 loadAEdge, loadBEdge, execEdge;
  logic [WIDTH:0]       addSum;
  logic [WIDTH-1:0]     subDiff;
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulNext;
  logic [WIDTH:0]       divShift;
  logic                 divGe;
  logic [WIDTH-1:0]     divDiff;
  logic [2*WIDTH-1:0]   divNext;

  assign loadAEdge = btnLoadA & ~loadAPrev_q;
  assign loadBEdge = btnLoadB & ~loadBPrev_q;
  assign execEdge  = btnExec & ~execPrev_q;

  assign addSum  = {1'b0, regA_q} + {1'b0, regB_q};
  assign subDiff = regA_q - regB_q;

  // Multiply: upper half accumulates, lower half holds the multiplier shifting out.
  assign mulSum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, aW_q} : '0);
  assign mulNext = {mulSum, work_q[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half trades dividend bits for quotient bits.
  assign divShift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, bW_q};
  assign divDiff  = divShift[WIDTH-1:0] - bW_q;
  assign divNext  = {(divGe ? divDiff : divShift[WIDTH-1:0]), work_q[WIDTH-2:0], divGe};

  always_comb begin
    state_d = state_q;
    regA_d  = regA_q;
    regB_d  = regB_q;
    aW_d    = aW_q;
    bW_d    = bW_q;
    opW_d   = opW_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    flag_d  = flag_q;
    done_d  = (state_q == DONE);

    if (state_q != RUN) begin
      if (loadAEdge) regA_d = inA;
      if (loadBEdge) regB_d = inB;
    end

    case (state_q)
      IDLE: begin
        if (execEdge) begin
          opW_d = op;
          aW_d  = regA_q;
          bW_d  = regB_q;
          cnt_d = '0;
          case (op)
            OP_ADD: begin
              led_d   = {{(WIDTH-1){1'b0}}, addSum};
              flag_d  = addSum[WIDTH];
              state_d = DONE;
            end
            OP_SUB: begin
              led_d   = {{WIDTH{1'b0}}, subDiff};
              flag_d  = (regA_q < regB_q);
              state_d = DONE;
            end
            OP_MUL: begin
              work_d  = {{WIDTH{1'b0}}, regB_q};
              state_d = RUN;
            end
            OP_DIV, OP_MOD: begin
              if (regB_q == '0) begin
                led_d   = '0;
                flag_d  = 1'b1;
                state_d = DONE;
              end else begin
                work_d  = {{WIDTH{1'b0}}, regA_q};
                state_d = RUN;
              end
            end
            default: begin
              led_d   = '0;
              flag_d  = 1'b1;
              state_d = DONE;
            end
          endcase
        end
      end
      RUN: begin
        cnt_d  = cnt_q + 1'b1;
        work_d = (opW_q == OP_MUL) ? mulNext : divNext;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          flag_d  = 1'b0;
          if (opW_q == OP_MUL)      led_d = mulNext;
          else if (opW_q == OP_DIV) led_d = {{WIDTH{1'b0}}, divNext[WIDTH-1:0]};
          else                      led_d = {{WIDTH{1'b0}}, divNext[2*WIDTH-1:WIDTH]};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      loadAPrev_q <= 1'b0;
      loadBPrev_q <= 1'b0;
      execPrev_q  <= 1'b0;
      regA_q      <= '0;
      regB_q      <= '0;
      aW_q        <= '0;
      bW_q        <= '0;
      opW_q       <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      led_q       <= '0;
      flag_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      loadAPrev_q <= btnLoadA;
      loadBPrev_q <= btnLoadB;
      execPrev_q  <= btnExec;
      regA_q      <= regA_d;
      regB_q      <= regB_d;
      aW_q        <= aW_d;
      bW_q        <= bW_d;
      opW_q       <= opW_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      flag_q      <= flag_d;
      done_q      <= done_d;
    end
  end

  assign led_out  = led_q;
  assign flag_out = flag_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule
